fetch_queue: RTL

- Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and drives the combinational-read instruction memory address.
- Buffers up to DEPTH fetched {pc, instruction} pairs so decode can stall without stalling fetch.
- Flushes on a branch redirect from ID and restarts fetch at the redirect target.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_queue_ram.sv | 31 +++
 rtl/fetch_queue.sv | 111 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    // One buffered fetch: the PC it was fetched from and the word returned.
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Fixed-width ISA: sequential fetch advances by one 32-bit word.
    localparam int INSTR_BYTES = 4;

endpackage : fetch_pkg

// File: rtl/fetch_queue_ram.sv
// DEPTH-entry register array of fetch entries: one write port, one
// combinational read port.
module fetch_queue_ram
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         we,
    input  logic [AW-1:0] waddr,
    input  fetch_entry_t wdata,
    input  logic [AW-1:0] raddr,
    output fetch_entry_t rdata
);

    fetch_entry_t mem_q [DEPTH];

    // Capture the written entry; slots are only ever read after being written.
    // NOTE: storage has no reset on purpose -- the pointers and count define
    // which slots are live, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Combinational read so the head entry reaches decode with no added cycle.
    assign rdata = mem_q[raddr];

endmodule : fetch_queue_ram

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, buffers fetched
// {pc, instr} pairs for decode, and flushes/restarts on a branch redirect.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fetch_en,
    output logic [63:0]              imem_addr,
    input  logic [31:0]              imem_instr,
    output logic                     deq_valid,
    input  logic                     deq_ready,
    output logic [63:0]              deq_pc,
    output logic [31:0]              deq_instr,
    input  logic                     redirect_valid,
    input  logic [63:0]              redirect_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int                 PTR_W      = $clog2(DEPTH);
    localparam int                 CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0]   FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [PTR_W-1:0]   PTR_ONE    = PTR_W'(1);
    localparam logic [63:0]        PC_STEP    = 64'(INSTR_BYTES);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [63:0]      fetch_pc_q, fetch_pc_d;
    logic             enq;
    logic             deq;
    fetch_entry_t     wr_entry;
    fetch_entry_t     rd_entry;

    // A redirect hides the head so a wrong-path instruction is never consumed;
    // a full queue still accepts a fetch when the head leaves the same cycle.
    assign deq_valid = (count_q != '0) && !redirect_valid;
    assign deq       = deq_valid && deq_ready;
    assign enq       = fetch_en && !redirect_valid && ((count_q < FULL_COUNT) || deq);

    assign wr_entry  = '{pc: fetch_pc_q, instr: imem_instr};

    // Next-state for pointers, occupancy and fetch PC; redirect wins over all.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        fetch_pc_d = fetch_pc_q;

        if (redirect_valid) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            fetch_pc_d = redirect_pc;
        end else begin
            if (deq) begin
                head_d = head_q + PTR_ONE;
            end
            if (enq) begin
                tail_d     = tail_q + PTR_ONE;
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
            if (enq && !deq) begin
                count_d = count_q + CNT_ONE;
            end else if (deq && !enq) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    // Control registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            fetch_pc_q <= RESET_PC;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    fetch_queue_ram #(
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (enq),
        .waddr (tail_q),
        .wdata (wr_entry),
        .raddr (head_q),
        .rdata (rd_entry)
    );

    assign imem_addr = fetch_pc_q;
    assign deq_pc    = rd_entry.pc;
    assign deq_instr = rd_entry.instr;
    assign count     = count_q;

endmodule : fetch_queue
